// File: rtl/tod_clock_core.sv
// Time-of-day core: binary hh:mm:ss advanced once per CLK_DIV cycles, with
// edge-triggered, range-checked CPU loads of hours and minutes.
module tod_clock_core #(
    parameter int unsigned CLK_DIV = 50000000,
    parameter int unsigned CNT_W   = 26
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       load_enable,
    input  logic [6:0] in_hours,
    input  logic [6:0] in_minutes,
    output logic [6:0] out_hours,
    output logic [6:0] out_minutes,
    output logic [5:0] out_seconds,
    output logic       sec_tick,
    output logic       load_ack,
    output logic       load_err
);

    logic [CNT_W-1:0] prescaler_q, prescaler_d;
    logic [6:0]       hours_q, hours_d;
    logic [6:0]       minutes_q, minutes_d;
    logic [5:0]       seconds_q, seconds_d;
    logic             sec_tick_q, sec_tick_d;
    logic             load_ack_q, load_ack_d;
    logic             load_err_q, load_err_d;
    logic             load_en_q;

    logic load_req;
    logic load_valid;
    logic terminal;

    assign load_req   = load_enable & ~load_en_q;
    assign load_valid = (in_hours < 7'd24) && (in_minutes < 7'd60);
    assign terminal   = (prescaler_q == CNT_W'(CLK_DIV - 1));

    always_comb begin
        prescaler_d = prescaler_q;
        hours_d     = hours_q;
        minutes_d   = minutes_q;
        seconds_d   = seconds_q;
        sec_tick_d  = 1'b0;
        load_ack_d  = 1'b0;
        load_err_d  = load_err_q;

        if (load_req && load_valid) begin
            // A load swallows any coinciding tick and restarts the second.
            hours_d     = in_hours;
            minutes_d   = in_minutes;
            seconds_d   = 6'd0;
            prescaler_d = '0;
            load_ack_d  = 1'b1;
            load_err_d  = 1'b0;
        end else begin
            if (load_req) begin
                load_err_d = 1'b1;
            end
            if (terminal) begin
                prescaler_d = '0;
                sec_tick_d  = 1'b1;
                if (seconds_q == 6'd59) begin
                    seconds_d = 6'd0;
                    if (minutes_q == 7'd59) begin
                        minutes_d = 7'd0;
                        hours_d   = (hours_q == 7'd23) ? 7'd0 : hours_q + 7'd1;
                    end else begin
                        minutes_d = minutes_q + 7'd1;
                    end
                end else begin
                    seconds_d = seconds_q + 6'd1;
                end
            end else begin
                prescaler_d = prescaler_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            prescaler_q <= '0;
            hours_q     <= 7'd0;
            minutes_q   <= 7'd0;
            seconds_q   <= 6'd0;
            sec_tick_q  <= 1'b0;
            load_ack_q  <= 1'b0;
            load_err_q  <= 1'b0;
            load_en_q   <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            hours_q     <= hours_d;
            minutes_q   <= minutes_d;
            seconds_q   <= seconds_d;
            sec_tick_q  <= sec_tick_d;
            load_ack_q  <= load_ack_d;
            load_err_q  <= load_err_d;
            load_en_q   <= load_enable;
        end
    end

    assign out_hours   = hours_q;
    assign out_minutes = minutes_q;
    assign out_seconds = seconds_q;
    assign sec_tick    = sec_tick_q;
    assign load_ack    = load_ack_q;
    assign load_err    = load_err_q;

endmodule

// File: tb/tb_tod_clock_core.sv
// Bench for tod_clock_core: cycle model feeding a scoreboard queue, plus
// directed checks of the load, carry, edge-detect and reset behaviour.
module tb_tod_clock_core;

    localparam int unsigned CLK_DIV = 4;

    logic       CLOCK_50;
    logic       reset;
    logic       load_enable;
    logic [6:0] in_hours;
    logic [6:0] in_minutes;
    logic [6:0] out_hours;
    logic [6:0] out_minutes;
    logic [5:0] out_seconds;
    logic       sec_tick;
    logic       load_ack;
    logic       load_err;

    tod_clock_core #(
        .CLK_DIV(CLK_DIV),
        .CNT_W  (3)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .load_enable(load_enable),
        .in_hours   (in_hours),
        .in_minutes (in_minutes),
        .out_hours  (out_hours),
        .out_minutes(out_minutes),
        .out_seconds(out_seconds),
        .sec_tick   (sec_tick),
        .load_ack   (load_ack),
        .load_err   (load_err)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int hr;
        int mn;
        int sc;
        int tick;
        int ack;
        int err;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Reference state: time kept as seconds since midnight.
    int m_pre = 0;
    int m_tod = 0;
    int m_tick = 0;
    int m_ack = 0;
    int m_err = 0;
    int m_lq = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit   req;
        exp_t e;
        req = load_enable && (m_lq == 0);
        if (reset) begin
            m_pre = 0; m_tod = 0; m_tick = 0; m_ack = 0; m_err = 0; m_lq = 0;
        end else begin
            m_tick = 0;
            m_ack  = 0;
            if (req && in_hours < 24 && in_minutes < 60) begin
                m_tod = int'(in_hours) * 3600 + int'(in_minutes) * 60;
                m_pre = 0;
                m_ack = 1;
                m_err = 0;
            end else begin
                if (req) m_err = 1;
                if (m_pre == CLK_DIV - 1) begin
                    m_pre  = 0;
                    m_tod  = (m_tod + 1) % 86400;
                    m_tick = 1;
                end else begin
                    m_pre++;
                end
            end
            m_lq = load_enable ? 1 : 0;
        end
        e.hr = m_tod / 3600;
        e.mn = (m_tod / 60) % 60;
        e.sc = m_tod % 60;
        e.tick = m_tick;
        e.ack = m_ack;
        e.err = m_err;
        sb.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge CLOCK_50);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            check("sb_hours", 32'(out_hours), 32'(e.hr));
            check("sb_minutes", 32'(out_minutes), 32'(e.mn));
            check("sb_seconds", 32'(out_seconds), 32'(e.sc));
            check("sb_tick", 32'(sec_tick), 32'(e.tick));
            check("sb_ack", 32'(load_ack), 32'(e.ack));
            check("sb_err", 32'(load_err), 32'(e.err));
        end
    endtask

    task automatic expect_time(input string tag, input int h, input int m, input int s);
        check({tag, "_h"}, 32'(out_hours), 32'(h));
        check({tag, "_m"}, 32'(out_minutes), 32'(m));
        check({tag, "_s"}, 32'(out_seconds), 32'(s));
    endtask

    initial begin
        int acks;
        int guard;
        reset       = 1'b1;
        load_enable = 1'b0;
        in_hours    = 7'd0;
        in_minutes  = 7'd0;
        #2;

        // Reset and first tick.
        cycle();
        cycle();
        expect_time("rst", 0, 0, 0);
        check("rst_tick", 32'(sec_tick), 32'd0);
        check("rst_ack", 32'(load_ack), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        reset = 1'b0;
        repeat (3) cycle();
        expect_time("idle3", 0, 0, 0);
        check("idle3_tick", 32'(sec_tick), 32'd0);
        cycle();
        check("first_tick", 32'(sec_tick), 32'd1);
        check("first_tick_s", 32'(out_seconds), 32'd1);

        // 23:59 rolls over to 00:00:00 in one step on the 60th tick.
        load_enable = 1'b1; in_hours = 7'd23; in_minutes = 7'd59;
        cycle();
        expect_time("ld2359", 23, 59, 0);
        check("ld2359_ack", 32'(load_ack), 32'd1);
        load_enable = 1'b0;
        cycle();
        check("ld2359_ack_off", 32'(load_ack), 32'd0);
        repeat (238) cycle();
        expect_time("pre_wrap", 23, 59, 59);
        cycle();
        expect_time("wrap", 0, 0, 0);
        check("wrap_tick", 32'(sec_tick), 32'd1);

        // Valid load 14:37.
        load_enable = 1'b1; in_hours = 7'd14; in_minutes = 7'd37;
        cycle();
        expect_time("ld1437", 14, 37, 0);
        check("ld1437_ack", 32'(load_ack), 32'd1);
        check("ld1437_err", 32'(load_err), 32'd0);
        load_enable = 1'b0;
        cycle();
        check("ld1437_ack_pulse", 32'(load_ack), 32'd0);

        // Out-of-range request, then a valid 1:00 clears the error.
        load_enable = 1'b1; in_hours = 7'd24; in_minutes = 7'd10;
        cycle();
        check("bad_h", 32'(out_hours), 32'd14);
        check("bad_m", 32'(out_minutes), 32'd37);
        check("bad_ack", 32'(load_ack), 32'd0);
        check("bad_err", 32'(load_err), 32'd1);
        load_enable = 1'b0;
        repeat (3) cycle();
        check("bad_err_sticky", 32'(load_err), 32'd1);
        load_enable = 1'b1; in_hours = 7'd1; in_minutes = 7'd0;
        cycle();
        expect_time("ld0100", 1, 0, 0);
        check("ld0100_err", 32'(load_err), 32'd0);
        check("ld0100_ack", 32'(load_ack), 32'd1);
        load_enable = 1'b0;
        cycle();

        // Held load_enable loads once; later input changes are ignored.
        load_enable = 1'b1; in_hours = 7'd2; in_minutes = 7'd30;
        cycle();
        acks = load_ack ? 1 : 0;
        for (int i = 0; i < 19; i++) begin
            in_minutes = 7'(i * 5);
            cycle();
            if (load_ack) acks++;
        end
        check("hold_acks", 32'(acks), 32'd1);
        expect_time("hold", 2, 30, 4);
        load_enable = 1'b0; in_minutes = 7'd0;
        cycle();

        // Load on the terminal-count cycle suppresses that tick.
        guard = 0;
        while (m_pre != CLK_DIV - 1 && guard < 2 * CLK_DIV) begin
            cycle();
            guard++;
        end
        check("align_tc", 32'(m_pre), 32'(CLK_DIV - 1));
        load_enable = 1'b1; in_hours = 7'd5; in_minutes = 7'd6;
        cycle();
        check("tc_ld_tick", 32'(sec_tick), 32'd0);
        check("tc_ld_ack", 32'(load_ack), 32'd1);
        expect_time("tc_ld", 5, 6, 0);
        load_enable = 1'b0;
        repeat (3) cycle();
        check("tc_ld_notick", 32'(sec_tick), 32'd0);
        cycle();
        check("tc_ld_tick4", 32'(sec_tick), 32'd1);
        check("tc_ld_tick4_s", 32'(out_seconds), 32'd1);
        repeat (24) cycle();
        expect_time("t050607", 5, 6, 7);

        // Mid-count reset clears everything on the next cycle.
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        expect_time("mid_rst", 0, 0, 0);
        check("mid_rst_tick", 32'(sec_tick), 32'd0);
        check("mid_rst_ack", 32'(load_ack), 32'd0);

        // load_enable already high at reset release counts as an edge.
        load_enable = 1'b1; in_hours = 7'd3; in_minutes = 7'd4;
        cycle();
        reset = 1'b0;
        cycle();
        expect_time("rel_ld", 3, 4, 0);
        check("rel_ld_ack", 32'(load_ack), 32'd1);
        load_enable = 1'b0;
        repeat (2) cycle();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
